// File: rtl/gth_link_seq.sv
// gth_link_seq: GTH link bring-up/recovery sequencer with retry, timeout and loss counting
module gth_link_seq #(
  parameter int RST_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES    = 8,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        restart,
  input  logic [3:0]  gth_status,
  input  logic        rxclk_vld,
  output logic        gth_rst,
  output logic        link_up,
  output logic        fail,
  output logic [2:0]  state,
  output logic [7:0]  retry_cnt,
  output logic [15:0] loss_cnt
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_PLL  = 3'd2,
    WAIT_DONE = 3'd3,
    STABLE    = 3'd4,
    UP        = 3'd5,
    FAIL      = 3'd6
  } state_t;
  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_END  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [8:0]       MAX_R   = (MAX_RETRIES > 255) ? 9'd256 : 9'(MAX_RETRIES);
  state_t           state_q, state_d, fail_next;
  logic [4:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d, retry_inc;
  logic [15:0]      loss_q, loss_d;
  logic             gth_rst_q, gth_rst_d, link_up_q, link_up_d, fail_q, fail_d;
  logic             pll_ok, done_ok, fail_evt;
  always_comb begin
    pll_ok    = sync2_q[0];
    done_ok   = &sync2_q[4:1];
    retry_inc = (&retry_q) ? retry_q : retry_q + 8'd1;
    fail_next = (MAX_R != 9'd0 && {1'b0, retry_inc} >= MAX_R) ? FAIL : RESET;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_q;
    loss_d    = loss_q;
    fail_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = RESET;
      end
      RESET: if (cnt_q == RST_END) begin
        state_d = WAIT_PLL;
        cnt_d   = '0;
      end
      WAIT_PLL: if (pll_ok) begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end else fail_evt = (cnt_q == TO_END);
      WAIT_DONE: if (!pll_ok) fail_evt = 1'b1;
      else if (done_ok) begin
        state_d = STABLE;
        cnt_d   = '0;
      end else fail_evt = (cnt_q == TO_END);
      STABLE: if (!(pll_ok && done_ok)) fail_evt = 1'b1;
      else if (cnt_q == ST_END) begin
        state_d = UP;
        cnt_d   = '0;
        retry_d = '0;
      end
      UP: begin
        cnt_d = '0;
        if (!(pll_ok && done_ok)) begin
          state_d = RESET;
          retry_d = '0;
          loss_d  = (&loss_q) ? loss_q : loss_q + 16'd1;
        end
      end
      FAIL: cnt_d = '0;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (fail_evt) begin
      state_d = fail_next;
      retry_d = retry_inc;
      cnt_d   = '0;
    end
    // enable low beats restart; neither counts as a link loss
    if (!enable || restart) begin
      state_d = enable ? RESET : IDLE;
      retry_d = '0;
      cnt_d   = '0;
      loss_d  = loss_q;
    end
    gth_rst_d = (state_d == IDLE) || (state_d == RESET) || (state_d == FAIL);
    link_up_d = (state_d == UP);
    fail_d    = (state_d == FAIL);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      gth_rst_q <= 1'b1;
      link_up_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync1_q   <= {rxclk_vld, gth_status};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      gth_rst_q <= gth_rst_d;
      link_up_q <= link_up_d;
      fail_q    <= fail_d;
    end
  end
  assign gth_rst   = gth_rst_q;
  assign link_up   = link_up_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
endmodule

// File: doc/gth_link_seq.md
Name: gth_link_seq

Overview:
- Bring-up and recovery sequencer for the SFP0 GTH serial link.
- Drives the GTH reset, waits for PLL lock, reset-done and RX-clock-valid, then qualifies stability and asserts link_up.
- On timeout it retries a bounded number of times. On loss of lock it re-sequences and counts the event.
- Sits beside gth_driver in system_top; status and counters are read by software through the system wrapper.

Parameters:
RST_CYCLES, 64, cycles gth_rst is held high per attempt (>=1)
TIMEOUT_CYCLES, 1000000, max cycles waiting for lock/done per attempt (>=1)
STABLE_CYCLES, 256, cycles all status must stay good before link_up (>=1)
MAX_RETRIES, 8, failed attempts before FAIL; 0 = retry forever
CNT_W, 24, width of the internal cycle counter; must hold max(RST_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES)

Ports:
clk  in  1  sequencer clock, free-running (dma_clk domain)
resetn  in  1  asynchronous active-low reset
enable  in  1  1 = run sequence; 0 = hold GTH in reset
restart  in  1  single-cycle pulse: abort and restart from RESET, clearing retry and FAIL
gth_status  in  4  [0] qpll lock, [1] tx reset done, [2] rx reset done, [3] rx cdr lock; asynchronous
rxclk_vld  in  1  recovered rx clock valid; asynchronous
gth_rst  out  1  reset to gth_driver, active high
link_up  out  1  link qualified and stable
fail  out  1  retries exhausted; sticky until restart, enable low or reset
state  out  3  current state encoding, for debug
retry_cnt  out  8  failed attempts in current bring-up; saturates at 255
loss_cnt  out  16  link-loss events since reset; saturates at 65535

Behaviour:
- Synchronization: gth_status and rxclk_vld pass through 2-flop synchronizers. The FSM uses only synchronized values (2-cycle latency). Define pll_ok = s[0]; done_ok = s[1]&s[2]&s[3]&vld.
- Reset values: gth_rst=1, link_up=0, fail=0, state=IDLE, retry_cnt=0, loss_cnt=0, cycle counter=0, synchronizers=0.
- States: IDLE=0, RESET=1, WAIT_PLL=2, WAIT_DONE=3, STABLE=4, UP=5, FAIL=6.
- IDLE: gth_rst=1. Goes to RESET when enable=1. Counter cleared.
- RESET: gth_rst=1 for exactly RST_CYCLES cycles, then WAIT_PLL with counter cleared. gth_rst is 0 in every state except IDLE, RESET and FAIL.
- WAIT_PLL: pll_ok -> WAIT_DONE (counter cleared). Counter reaching TIMEOUT_CYCLES-1 without pll_ok is a timeout.
- WAIT_DONE: pll_ok & done_ok -> STABLE (counter cleared). Timeout on the same rule as WAIT_PLL. Loss of pll_ok is an immediate failure.
- STABLE: any of pll_ok/done_ok low -> failure. After STABLE_CYCLES consecutive good cycles -> UP.
- link_up is registered, =1 exactly while state==UP.
- UP: any of pll_ok/done_ok low -> loss_cnt+1 (saturating), retry_cnt cleared, go RESET. link_up drops the cycle state leaves UP.
- Failure / timeout handling:
  - retry_cnt+1 (saturating).
  - If MAX_RETRIES!=0 and the incremented value reaches MAX_RETRIES -> FAIL.
  - Otherwise -> RESET.
- FAIL: gth_rst=1, fail=1. Leaves only on restart (-> RESET) or enable=0 (-> IDLE).
- retry_cnt clears on entry to UP, on restart and on enable=0.
- enable=0 in any state -> IDLE next cycle. Clears fail and retry_cnt; loss_cnt is kept.
- restart=1 with enable=1 -> RESET from any state; overrides all other transitions the same cycle. It does not count as a loss even from UP.
- Priority per cycle: enable=0 > restart > state transition.
- Asynchronous reset mid-sequence forces all reset values immediately. Outputs are glitch-free registers.

Test Plan:
- Params RST=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=3:
  - enable=1, all status and vld high from start -> gth_rst high 4 cycles, then low.
  - link_up rises RST+STABLE+sync+transition cycles after enable, checked exactly against the model.
  - retry_cnt=0.
- pll_ok never asserts -> three 20-cycle timeouts, retry_cnt=1,2,3, then state=FAIL, fail=1, gth_rst=1.
  - restart pulse -> fail=0, retry_cnt=0, state=RESET.
- Link UP, then drop gth_status[3] for 1 cycle:
  - link_up falls 3 cycles later (sync+FSM), loss_cnt=1, gth_rst reasserts for 4 cycles.
  - Link re-qualifies on recovery.
- Toggle rxclk_vld low at STABLE cycle 5 -> failure, retry_cnt=1, STABLE counter restarts from 0 after the re-sequence.
- enable=0 while in WAIT_DONE with restart=1 the same cycle -> IDLE (enable wins), gth_rst=1, loss_cnt unchanged.
- Assert resetn low during STABLE -> all outputs at reset values asynchronously. Sequence restarts from IDLE on release.
